// File: rtl/fetch_decode.sv
// fetch_decode: latches the fetched byte into ir every cycle and decodes flow control into PC load/skip strobes.
// ir/ir_valid are registered, strobes are combinational from ir; FETCH_DECODE_PERF_EN adds instr/flush counters.
module fetch_decode #(
  parameter logic [3:0] TWO_BYTE_LO = 4'h8,
  parameter logic [7:0] NOP_OP      = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pc,
  output logic [7:0]  imem_addr,
  input  logic [7:0]  imem_data,
  input  logic        flag_z,
  input  logic        flag_c,
  output logic [7:0]  ir,
  output logic        ir_valid,
  output logic [7:0]  operand,
  output logic [7:0]  K,
  output logic        sel_pc,
  output logic        sel_br
`ifdef FETCH_DECODE_PERF_EN
  ,
  output logic [15:0] instr_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic {DISCARD = 1'b0, VALID = 1'b1} state_t;

  localparam logic [3:0] OP_LDI = TWO_BYTE_LO;
  localparam logic [3:0] OP_JMP = TWO_BYTE_LO + 4'd1;
  localparam logic [3:0] OP_JZ  = TWO_BYTE_LO + 4'd2;
  localparam logic [3:0] OP_JC  = TWO_BYTE_LO + 4'd3;
  localparam logic [3:0] OP_SKZ = 4'hC;
  localparam logic [3:0] OP_SKC = 4'hD;

  state_t     state, state_nxt;
  logic [3:0] opc;
  logic       skip_taken;

  function automatic logic is_two_byte(input logic [3:0] op);
    logic [3:0] d;
    d = op - TWO_BYTE_LO;
    return d < 4'd4;
  endfunction

  assign imem_addr = pc;
  assign operand   = imem_data;
  assign K         = imem_data;
  assign opc       = ir[7:4];
  assign ir_valid  = (state == VALID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DISCARD;
      ir    <= NOP_OP;
    end else begin
      state <= state_nxt;
      ir    <= imem_data;
    end
  end

  always_comb begin
    skip_taken = ((opc == OP_SKZ) && flag_z) || ((opc == OP_SKC) && flag_c);
    sel_pc     = 1'b0;
    sel_br     = 1'b0;
    state_nxt  = VALID;
    if (state == VALID) begin
      sel_pc = (opc == OP_JMP) || ((opc == OP_JZ) && flag_z) || ((opc == OP_JC) && flag_c);
      // a skipped two-byte instruction needs the PC to hop over its operand too
      sel_br = skip_taken && is_two_byte(imem_data[7:4]);
      if (is_two_byte(opc) || skip_taken) begin
        state_nxt = DISCARD;
      end
    end
  end

`ifdef FETCH_DECODE_PERF_EN
  logic from_reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      from_reset <= 1'b1;
      instr_cnt  <= 16'h0000;
      flush_cnt  <= 16'h0000;
    end else begin
      from_reset <= 1'b0;
      if (ir_valid && (instr_cnt != 16'hFFFF)) begin
        instr_cnt <= instr_cnt + 16'd1;
      end
      // the discard cycle that follows reset release is not a flush
      if (!ir_valid && !from_reset && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: constant vectors, directed multi-cycle sequences, and random programs vs an ISA-level model.
module tb_fetch_decode;

  logic       clk;
  logic       reset;
  logic [7:0] pc_r;
  logic [7:0] imem_addr, imem_data;
  logic       flag_z, flag_c;
  logic [7:0] ir, operand, K;
  logic       ir_valid, sel_pc, sel_br;
`ifdef FETCH_DECODE_PERF_EN
  logic [15:0] instr_cnt, flush_cnt;
`endif

  logic [7:0] mem [256];
  int n_chk;
  int n_pass;

  fetch_decode dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc_r),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .operand   (operand),
    .K         (K),
    .sel_pc    (sel_pc),
    .sel_br    (sel_br)
`ifdef FETCH_DECODE_PERF_EN
    ,
    .instr_cnt (instr_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter block sitting downstream of the strobes
  always @(posedge clk or negedge reset) begin
    if (!reset) pc_r <= 8'h00;
    else if (sel_pc) pc_r <= K;
    else pc_r <= pc_r + (sel_br ? 8'd2 : 8'd1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    flag_z = 1'b0;
    flag_c = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_state", {ir_valid, ir, sel_pc, sel_br}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic step(input logic fz, input logic fc);
    @(negedge clk);
    flag_z = fz;
    flag_c = fc;
    #1;
  endtask

  task automatic goto_op(input logic [7:0] tgt);
    mem[0] = 8'h90;
    mem[1] = tgt;
    do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] op;
    logic [7:0] nxt;
    logic fz, fc, e_pc, e_br, e_disc;
  } vec_t;
  vec_t vecs [14];

  logic [7:0] a, op, nb, nxt_addr, rb;
  logic       e_pc, e_br, e_d, fz_r, fc_r;
  int         exp_disc, nv, nd;

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    flag_z = 1'b0;
    flag_c = 1'b0;
    clear_mem();

    //            op     next   fz    fc    pc    br    disc
    vecs[0]  = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h90, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{8'hA0, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{8'hA0, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{8'hB0, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{8'hB0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'hC0, 8'h85, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{8'hC0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'hC0, 8'h85, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'hD0, 8'h8B, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{8'hD0, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h85, 8'h9F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{8'h7F, 8'h90, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'hE0, 8'hC0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      clear_mem();
      mem[0] = vecs[i].op;
      mem[1] = vecs[i].nxt;
      do_reset();
      step(1'b0, 1'b0);
      chk($sformatf("vec%0d_first_discard", i), ir_valid, 0);
      step(vecs[i].fz, vecs[i].fc);
      chk($sformatf("vec%0d_ir", i), {ir_valid, ir}, {1'b1, vecs[i].op});
      chk($sformatf("vec%0d_strobes", i), {sel_pc, sel_br}, {vecs[i].e_pc, vecs[i].e_br});
      chk($sformatf("vec%0d_K_operand", i), {K, operand}, {vecs[i].nxt, vecs[i].nxt});
      step(1'b0, 1'b0);
      chk($sformatf("vec%0d_next_valid", i), ir_valid, !vecs[i].e_disc);
    end

    // straight-line code then JMP 0x20
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    mem[4] = 8'h90; mem[5] = 8'h20; mem[8'h20] = 8'h55;
    do_reset();
    step(1'b0, 1'b0); chk("line_discard", ir_valid, 0);
    step(1'b0, 1'b0); chk("line_ir1", {ir_valid, ir, sel_pc, sel_br}, {1'b1, 8'h01, 2'b00});
    step(1'b0, 1'b0); chk("line_ir2", {ir_valid, ir, sel_pc, sel_br}, {1'b1, 8'h02, 2'b00});
    step(1'b0, 1'b0); chk("line_ir3", {ir_valid, ir, sel_pc, sel_br}, {1'b1, 8'h03, 2'b00});
    step(1'b0, 1'b0); chk("line_ir4", {ir_valid, ir}, {1'b1, 8'h04});
    step(1'b0, 1'b0); chk("jmp_strobe", {ir_valid, ir, sel_pc, sel_br, K}, {1'b1, 8'h90, 2'b10, 8'h20});
    step(1'b0, 1'b0); chk("jmp_discard", {ir_valid, sel_pc}, 2'b00);
    step(1'b0, 1'b0); chk("jmp_target", {ir_valid, ir}, {1'b1, 8'h55});

    // JZ 0x40 at 0x10, not taken then taken
    clear_mem();
    mem[8'h10] = 8'hA0; mem[8'h11] = 8'h40; mem[8'h12] = 8'h66; mem[8'h40] = 8'h77;
    goto_op(8'h10);
    step(1'b0, 1'b0); chk("jz_nt_strobes", {ir_valid, ir, sel_pc, sel_br}, {1'b1, 8'hA0, 2'b00});
    step(1'b0, 1'b0); chk("jz_nt_discard", ir_valid, 0);
    step(1'b0, 1'b0); chk("jz_nt_next", {ir_valid, ir}, {1'b1, 8'h66});
    goto_op(8'h10);
    step(1'b1, 1'b0); chk("jz_t_strobes", {ir_valid, sel_pc, sel_br, K}, {1'b1, 2'b10, 8'h40});
    step(1'b1, 1'b0); chk("jz_t_discard", {ir_valid, sel_pc}, 2'b00);
    step(1'b0, 1'b0); chk("jz_t_target", {ir_valid, ir}, {1'b1, 8'h77});

    // SKZ at 0x30 over a two-byte then a one-byte instruction
    clear_mem();
    mem[8'h30] = 8'hC0; mem[8'h31] = 8'h85; mem[8'h32] = 8'h11; mem[8'h33] = 8'h22;
    goto_op(8'h30);
    step(1'b1, 1'b0); chk("skz2_strobes", {ir_valid, ir, sel_pc, sel_br}, {1'b1, 8'hC0, 2'b01});
    step(1'b0, 1'b0); chk("skz2_discard", ir_valid, 0);
    step(1'b0, 1'b0); chk("skz2_next", {ir_valid, ir}, {1'b1, 8'h22});
    mem[8'h31] = 8'h01;
    goto_op(8'h30);
    step(1'b1, 1'b0); chk("skz1_strobes", {ir_valid, sel_pc, sel_br}, {1'b1, 2'b00});
    step(1'b0, 1'b0); chk("skz1_discard", ir_valid, 0);
    step(1'b0, 1'b0); chk("skz1_next", {ir_valid, ir}, {1'b1, 8'h11});

    // LDI immediates that look like jumps are never decoded
    clear_mem();
    mem[0] = 8'h85; mem[1] = 8'h7E; mem[2] = 8'h85; mem[3] = 8'h9F; mem[4] = 8'h01;
    do_reset();
    step(1'b0, 1'b0);
    step(1'b1, 1'b1); chk("ldi_operand", {ir_valid, ir, operand, sel_pc, sel_br}, {1'b1, 8'h85, 8'h7E, 2'b00});
    step(1'b1, 1'b1); chk("ldi_discard", {ir_valid, sel_pc, sel_br}, 3'b000);
    step(1'b1, 1'b1); chk("ldi2_operand", {ir_valid, operand, sel_pc}, {1'b1, 8'h9F, 1'b0});
    step(1'b1, 1'b1); chk("ldi2_imm_not_jump", {ir_valid, ir, sel_pc, sel_br}, {1'b0, 8'h9F, 2'b00});
    step(1'b1, 1'b1); chk("ldi2_next", {ir_valid, ir}, {1'b1, 8'h01});

    // asynchronous reset while a JMP is being executed
    clear_mem();
    mem[0] = 8'h90; mem[1] = 8'h20;
    do_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0); chk("midrst_jmp", {ir_valid, sel_pc}, 2'b11);
    #2 reset = 1'b0;
    #1 chk("midrst_async", {ir_valid, ir, sel_pc, sel_br}, 32'h0);
`ifdef FETCH_DECODE_PERF_EN
    chk("midrst_counters", {instr_cnt, flush_cnt}, 32'h0);
`endif

    // random programs against an instruction-level model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) begin
        rb = 8'($urandom);
        if ($urandom_range(0, 1) == 1) rb[7:4] = 4'($urandom_range(8, 13));
        mem[i] = rb;
      end
      do_reset();
      exp_disc = 1;
      a = 8'h00;
      nv = 0;
      nd = 0;
      for (int c = 0; c < 500; c++) begin
        fz_r = 1'($urandom_range(0, 1));
        fc_r = 1'($urandom_range(0, 1));
        step(fz_r, fc_r);
`ifdef FETCH_DECODE_PERF_EN
        chk("rnd_instr_cnt", instr_cnt, nv);
        chk("rnd_flush_cnt", flush_cnt, (nd > 0) ? nd - 1 : 0);
`endif
        if (exp_disc > 0) begin
          chk("rnd_discard", {ir_valid, sel_pc, sel_br}, 3'b000);
          exp_disc = 0;
          nd++;
        end else begin
          op = mem[a];
          nb = mem[a + 8'd1];
          e_pc = 1'b0;
          e_br = 1'b0;
          e_d = 1'b0;
          nxt_addr = a + 8'd1;
          case (op[7:4])
            4'h8: begin nxt_addr = a + 8'd2; e_d = 1'b1; end
            4'h9: begin nxt_addr = nb; e_pc = 1'b1; e_d = 1'b1; end
            4'hA: begin e_d = 1'b1; e_pc = fz_r; nxt_addr = fz_r ? nb : a + 8'd2; end
            4'hB: begin e_d = 1'b1; e_pc = fc_r; nxt_addr = fc_r ? nb : a + 8'd2; end
            4'hC, 4'hD: begin
              if ((op[7:4] == 4'hC) ? fz_r : fc_r) begin
                e_d = 1'b1;
                e_br = (nb[7:4] >= 4'h8) && (nb[7:4] <= 4'hB);
                nxt_addr = a + 8'd1 + (e_br ? 8'd2 : 8'd1);
              end
            end
            default: ;
          endcase
          chk("rnd_ir", {ir_valid, ir}, {1'b1, op});
          chk("rnd_operand", operand, nb);
          chk("rnd_strobes", {sel_pc, sel_br}, {e_pc, e_br});
          a = nxt_addr;
          exp_disc = e_d ? 1 : 0;
          nv++;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
